// File: rtl/dm_arbiter_if.sv
// Bus bundle for dm_arbiter: two requester ports plus the data-memory side.
// The arbiter connects through the slave modport; the environment driving
// requesters and modelling memory uses the master modport.
interface dm_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;

    logic [AW-1:0] dm_read_addr;
    logic [AW-1:0] dm_write_addr;
    logic [DW-1:0] dm_write_data;
    logic          dm_we;
    logic [DW-1:0] dm_read_data;

    logic          busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  dm_read_data,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output dm_read_addr, dm_write_addr, dm_write_data, dm_we,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output dm_read_data,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  dm_read_addr, dm_write_addr, dm_write_data, dm_we,
        input  busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory.
// Each access takes IDLE -> RD/WR -> ACK -> IDLE; request fields are captured
// straight into the memory-side address/data registers at grant time.
module dm_arbiter #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
) (
    input  logic        clk,
    input  logic        rst_f,
    dm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_last;      // last granted port (0/1)
    logic          r_owner;     // port owning the in-flight access
    logic [AW-1:0] r_rd_addr;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_dm_we;
    logic [DW-1:0] r_p0_rdata;
    logic [DW-1:0] r_p1_rdata;

    logic          w_gnt_vld;
    logic          w_gnt;
    logic          w_gnt_we;
    logic [AW-1:0] w_gnt_addr;
    logic [DW-1:0] w_gnt_wdata;

    // Round-robin pick and request-field mux, then next-state decode
    always_comb begin
        w_gnt_vld   = bus.p0_req | bus.p1_req;
        w_gnt       = (bus.p0_req && bus.p1_req) ? ~r_last : bus.p1_req;
        w_gnt_we    = w_gnt ? bus.p1_we    : bus.p0_we;
        w_gnt_addr  = w_gnt ? bus.p1_addr  : bus.p0_addr;
        w_gnt_wdata = w_gnt ? bus.p1_wdata : bus.p0_wdata;
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_vld) w_state_nxt = w_gnt_we ? WR : RD;
            RD:      w_state_nxt = ACK;
            WR:      w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Grant capture, memory-side registers and read-result capture
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_dm_we    <= 1'b0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_owner <= w_gnt;
                        r_last  <= w_gnt;
                        if (w_gnt_we) begin
                            r_wr_addr <= w_gnt_addr;
                            r_wr_data <= w_gnt_wdata;
                            r_dm_we   <= 1'b1;
                        end else begin
                            r_rd_addr <= w_gnt_addr;
                        end
                    end
                end
                RD: begin
                    if (r_owner) r_p1_rdata <= bus.dm_read_data;
                    else         r_p0_rdata <= bus.dm_read_data;
                end
                WR:      r_dm_we <= 1'b0;   // falling edge commits the write
                default: ;
            endcase
        end
    end

    assign bus.dm_read_addr  = r_rd_addr;
    assign bus.dm_write_addr = r_wr_addr;
    assign bus.dm_write_data = r_wr_data;
    assign bus.dm_we         = r_dm_we;
    assign bus.p0_rdata      = r_p0_rdata;
    assign bus.p1_rdata      = r_p1_rdata;
    assign bus.p0_ack        = (r_state == ACK) && !r_owner;
    assign bus.p1_ack        = (r_state == ACK) &&  r_owner;
    assign bus.busy          = (r_state != IDLE);
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios followed by random
// two-port rounds, checked against a transaction-level reference model.
module tb_dm_arbiter;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_f;
    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus.slave)
    );

    // Memory environment: combinational read, commit on dm_we falling edge
    bit [DW-1:0] mem [0:(1<<AW)-1];
    bit          vld [0:(1<<AW)-1];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    assign bus.dm_read_data = vld[bus.dm_read_addr] ? mem[bus.dm_read_addr]
                                                    : pat(bus.dm_read_addr);

    always @(negedge bus.dm_we) begin
        if (rst_f === 1'b1) begin
            mem[bus.dm_write_addr] <= bus.dm_write_data;
            vld[bus.dm_write_addr] <= 1'b1;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_rdata [2];
    bit            m_last;
    int            n_assert = 0;
    int            n_fail   = 0;
    int            we_cnt   = 0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return pat(a);
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit req, input bit we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
        end
    endtask

    task automatic check_cycle(input string tag, input bit e0, input bit e1, input bit eb);
        chk({tag, "_ack0"}, DW'(bus.p0_ack), DW'(e0));
        chk({tag, "_ack1"}, DW'(bus.p1_ack), DW'(e1));
        chk({tag, "_busy"}, DW'(bus.busy), DW'(eb));
        if (bus.dm_we === 1'b1) we_cnt++;
    endtask

    // Called in the cycle a port's ack is due: apply the access to the model
    task automatic service(input int p, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        if (we) begin
            ref_mem[int'(a)] = d;
            chk("wr_addr_hold", DW'(bus.dm_write_addr), DW'(a));
            chk("wr_data_hold", bus.dm_write_data, d);
            chk("we_low_in_ack", DW'(bus.dm_we), '0);
        end else begin
            exp_rdata[p] = ref_rd(a);
        end
        chk("p0_rdata", bus.p0_rdata, exp_rdata[0]);
        chk("p1_rdata", bus.p1_rdata, exp_rdata[1]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack0"},  DW'(bus.p0_ack), '0);
        chk({tag, "_ack1"},  DW'(bus.p1_ack), '0);
        chk({tag, "_busy"},  DW'(bus.busy), '0);
        chk({tag, "_we"},    DW'(bus.dm_we), '0);
        chk({tag, "_raddr"}, DW'(bus.dm_read_addr), '0);
        chk({tag, "_waddr"}, DW'(bus.dm_write_addr), '0);
        chk({tag, "_wdata"}, bus.dm_write_data, '0);
        chk({tag, "_rd0"},   bus.p0_rdata, '0);
        chk({tag, "_rd1"},   bus.p1_rdata, '0);
    endtask

    task automatic model_reset();
        m_last       = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic do_reset();
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
        rst_f = 1'b0;
        #2;
        chk_reset_outputs("rst");
        tick();
        #3 rst_f = 1'b1;
        model_reset();
        tick();
    endtask

    // One arbitration round: each port in mask issues one access and holds
    // req until its ack; the model predicts order, ack cycles and data.
    task automatic round(input bit [1:0] mask,
                         input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int first;
        int second;
        bit both;
        int ac [2];
        int nwr;
        int we0_cnt;
        bit tw [2];
        logic [AW-1:0] ta [2];
        logic [DW-1:0] td [2];
        tw[0] = we0; ta[0] = a0; td[0] = d0;
        tw[1] = we1; ta[1] = a1; td[1] = d1;
        both   = (mask == 2'b11);
        first  = both ? (m_last ? 0 : 1) : (mask[1] ? 1 : 0);
        second = 1 - first;
        ac[0] = 0;
        ac[1] = 0;
        ac[first] = 2;
        if (both) ac[second] = 5;
        nwr = 0;
        for (int p = 0; p < 2; p++) begin
            if (mask[p]) begin
                set_port(p, 1, tw[p], ta[p], td[p]);
                if (tw[p]) nwr++;
            end
        end
        we0_cnt = we_cnt;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check_cycle("round", c == ac[0], c == ac[1],
                        (c <= 2) || (both && (c == 4 || c == 5)));
            for (int p = 0; p < 2; p++) begin
                if (c == ac[p]) begin
                    service(p, tw[p], ta[p], td[p]);
                    set_port(p, 0, 0, '0, '0);
                end
            end
        end
        chk("round_we_cycles", DW'(we_cnt - we0_cnt), DW'(nwr));
        m_last = both ? second[0] : first[0];
    endtask

    initial begin
        logic [DW-1:0] vals [4];
        int k;
        int w0;
        bit [1:0] rmask;

        // Reset state
        rst_f = 1'b0;
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
        model_reset();
        #3;
        chk_reset_outputs("init");
        @(posedge clk);
        #4 rst_f = 1'b1;
        tick();

        // Port 0 write then read of 0x0010
        w0 = we_cnt;
        round(2'b01, 1, 16'h0010, 32'hDEADBEEF, 0, '0, '0);
        chk("w_one_we_cycle", DW'(we_cnt - w0), 32'd1);
        round(2'b01, 0, 16'h0010, '0, 0, '0, '0);
        chk("rd_deadbeef", bus.p0_rdata, 32'hDEADBEEF);
        chk("p1_untouched", bus.p1_rdata, 32'h0);

        // Tie after reset: p0 first; p0 re-requests on its ack and loses the next tie
        do_reset();
        set_port(0, 1, 0, 16'h0300, '0);
        set_port(1, 1, 0, 16'h0301, '0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            check_cycle("tie", c == 2 || c == 8, c == 5,
                        c == 1 || c == 2 || c == 4 || c == 5 || c == 7 || c == 8);
            if (c == 2) begin
                service(0, 0, 16'h0300, '0);
                set_port(0, 1, 0, 16'h0302, '0);
            end
            if (c == 5) begin
                service(1, 0, 16'h0301, '0);
                set_port(1, 0, 0, '0, '0);
            end
            if (c == 8) begin
                service(0, 0, 16'h0302, '0);
                set_port(0, 0, 0, '0, '0);
            end
        end
        m_last = 1'b0;

        // Port 1 back-to-back writes to 0x0100..0x0103
        for (int i = 0; i < 4; i++) vals[i] = 32'hA0B0_0000 + DW'(i * 32'h1111);
        k  = 0;
        w0 = we_cnt;
        set_port(1, 1, 1, 16'h0100, vals[0]);
        for (int c = 1; c <= 12; c++) begin
            tick();
            check_cycle("b2b", 1'b0, (c % 3) == 2, (c % 3) != 0);
            if ((c % 3) == 2 && k < 4) begin
                service(1, 1, AW'(16'h0100 + k), vals[k]);
                k++;
                if (k < 4) set_port(1, 1, 1, AW'(16'h0100 + k), vals[k]);
                else       set_port(1, 0, 0, '0, '0);
            end
        end
        chk("b2b_we_cycles", DW'(we_cnt - w0), 32'd4);
        m_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            round(2'b10, 0, '0, '0, 0, AW'(16'h0100 + i), '0);
            chk("b2b_readback", bus.p1_rdata, vals[i]);
        end

        // Simultaneous read (p0) and write (p1) of 0x0020
        round(2'b11, 0, 16'h0020, '0, 1, 16'h0020, 32'h12345678);
        chk("rw_old_value", bus.p0_rdata, pat(16'h0020));
        round(2'b01, 0, 16'h0020, '0, 0, '0, '0);
        chk("rw_new_value", bus.p0_rdata, 32'h12345678);

        // Reset pulse during the WR cycle of a write to 0x0040
        set_port(0, 1, 1, 16'h0040, 32'hCAFEF00D);
        tick();
        chk("wr_we_high", DW'(bus.dm_we), 32'd1);
        chk("wr_busy", DW'(bus.busy), 32'd1);
        #2 rst_f = 1'b0;
        #1;
        chk_reset_outputs("midwr");
        set_port(0, 0, 0, '0, '0);
        #1 rst_f = 1'b1;
        model_reset();
        ref_mem.delete(int'(16'h0040));
        ref_mem.delete(0);
        for (int c = 1; c <= 2; c++) begin
            tick();
            check_cycle("post_rst", 1'b0, 1'b0, 1'b0);
        end
        round(2'b01, 0, 16'h0050, '0, 0, '0, '0);

        // Address change during RD is ignored
        set_port(0, 1, 0, 16'h0030, '0);
        tick();
        check_cycle("midrd1", 1'b0, 1'b0, 1'b1);
        set_port(0, 1, 0, 16'h0031, '0);
        tick();
        check_cycle("midrd2", 1'b1, 1'b0, 1'b1);
        service(0, 0, 16'h0030, '0);
        chk("midrd_value", bus.p0_rdata, pat(16'h0030));
        set_port(0, 0, 0, '0, '0);
        tick();
        check_cycle("midrd3", 1'b0, 1'b0, 1'b0);
        m_last = 1'b0;

        // Random rounds over a small shared address window
        for (int r = 0; r < 30; r++) begin
            rmask = 2'($urandom_range(1, 3));
            round(rmask,
                  1'($urandom_range(0, 1)), AW'(16'h0200 + $urandom_range(0, 7)), DW'($urandom),
                  1'($urandom_range(0, 1)), AW'(16'h0200 + $urandom_range(0, 7)), DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter AW, default 16, data-memory word-address width.
REQ-002 Parameter DW, default 32, data-memory word width.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_f  input  1  asynchronous active-low reset.
REQ-006 p0_req  input  1  port 0 (CPU) access request; held until p0_ack.
REQ-007 p0_we  input  1  port 0 direction, 1 = write, 0 = read.
REQ-008 p0_addr  input  AW  port 0 word address.
REQ-009 p0_wdata  input  DW  port 0 write data.
REQ-010 p0_ack  output  1  port 0 one-cycle completion pulse.
REQ-011 p0_rdata  output  DW  port 0 read result register.
REQ-012 p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata SHALL mirror the port 0 signals for port 1 (loader/DMA).
REQ-013 dm_read_addr  output  AW  data-memory read address.
REQ-014 dm_write_addr  output  AW  data-memory write address.
REQ-015 dm_write_data  output  DW  data-memory write data.
REQ-016 dm_we  output  1  data-memory write enable; memory commits on its falling edge.
REQ-017 dm_read_data  input  DW  data-memory combinational read result.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WR and ACK.
REQ-020 IDLE: with no req, stay in IDLE; otherwise grant one port, latch its we/addr/wdata, and go to RD (we=0) or WR (we=1).
REQ-021 Arbitration SHALL be round-robin: a single requester always wins; on simultaneous requests the port not granted last wins.
REQ-022 The last-granted register SHALL reset to port 1, so port 0 wins the first tie.
REQ-023 IDLE->RD edge: dm_read_addr SHALL load the latched address; dm_we stays 0.
REQ-024 RD->ACK edge: the owner's pN_rdata SHALL capture dm_read_data; the other port's rdata is unchanged.
REQ-025 IDLE->WR edge: dm_write_addr and dm_write_data SHALL load the latched values and dm_we SHALL go to 1.
REQ-026 WR->ACK edge: dm_we SHALL return to 0, producing the commit edge; write address and data SHALL be held unchanged through ACK.
REQ-027 dm_we SHALL be high for exactly one clock per write and never during RD, ACK or IDLE.
REQ-028 ACK: the owner's pN_ack SHALL be 1 for exactly this cycle; then go to IDLE unconditionally.
REQ-029 Latency: request sampled at edge k gives ack high in the cycle after edge k+1; one access completes every 3 cycles at most.
REQ-030 Requests SHALL be re-sampled only in IDLE; a requester that updates req/we/addr/wdata on the ack edge gets its new request considered immediately.
REQ-031 Changes to a req or its signals while that port is not in IDLE arbitration SHALL be ignored, because values are latched at grant.
REQ-032 pN_rdata SHALL hold its value until the next read completed for port N.
REQ-033 dm_read_addr, dm_write_addr and dm_write_data SHALL hold their last values when unused.

Reset
REQ-034 rst_f low SHALL immediately force: state IDLE, dm_we 0, p0_ack and p1_ack 0, busy 0, all address outputs 0x0000, dm_write_data, p0_rdata and p1_rdata 0x00000000, last-granted = port 1.
REQ-035 Reset during WR SHALL drop dm_we at once with no ack; memory content at the in-flight address and at address 0x0000 is then unspecified.
REQ-036 Reset during RD or ACK SHALL abort silently with no ack and no rdata update.
REQ-037 After rst_f deasserts, the first rising edge SHALL evaluate requests from IDLE.

Verification
REQ-038 Port 0 write 0xDEADBEEF to 0x0010, then port 0 read 0x0010 -> dm_we high one cycle, p0_ack pulses twice, p0_rdata = 0xDEADBEEF, p1_rdata = 0.
REQ-039 p0_req and p1_req both raised on the same edge after reset, both reads -> port 0 acked first, port 1 acked 3 cycles later; a repeated tie is then won by port 1 first.
REQ-040 Port 1 held continuously requesting 4 back-to-back writes to 0x0100..0x0103 -> 4 acks spaced 3 cycles apart; memory holds the 4 values.
REQ-041 Port 0 reads 0x0020 while port 1 writes 0x0020 with 0x12345678 (port 0 granted first) -> p0_rdata = old value; a later read returns 0x12345678.
REQ-042 rst_f pulsed low in the WR cycle of a write to 0x0040 -> dm_we 0 immediately, no ack, all outputs at reset values, next request serviced normally.
REQ-043 Port 0 changes p0_addr mid-RD from 0x0030 to 0x0031 -> read returns the contents of 0x0030.
